// File: rtl/dma_xfer_ctrl.sv
// Single-channel DMA sequencer: launches read/write command issuers and tracks RLAST/B completions.
// Accept at T, start pulses at T+1, done one cycle after the final event; job_ready low from launch through done.
module dma_xfer_ctrl #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES   = 4096
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [C_AXI_DATA_WIDTH-1:0] job_src,
    input  logic [C_AXI_DATA_WIDTH-1:0] job_dst,
    input  logic [15:0]                 job_size,
    output logic                        rd_start,
    output logic [C_AXI_DATA_WIDTH-1:0] rd_src_addr,
    output logic [15:0]                 rd_size,
    output logic                        wr_start,
    output logic [C_AXI_DATA_WIDTH-1:0] wr_dst_addr,
    output logic [15:0]                 wr_size,
    input  logic                        M_AXI_RVALID,
    input  logic                        M_AXI_RREADY,
    input  logic                        M_AXI_RLAST,
    input  logic                        M_AXI_BVALID,
    input  logic [1:0]                  M_AXI_BRESP,
    output logic                        M_AXI_BREADY,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [8:0]    nb;
    logic [8:0]    rd_cnt;
    logic [8:0]    wr_cnt;
    logic [TW-1:0] timer;

    logic          rd_evt;
    logic          wr_evt;
    logic [8:0]    rd_next;
    logic [8:0]    wr_next;
    logic          all_done;
    logic          timeout_hit;
    logic          unused_bresp0;

    // Events past the burst target are dropped so the counters saturate at nb.
    assign rd_evt      = (state == RUN) && M_AXI_RVALID && M_AXI_RREADY && M_AXI_RLAST
                         && (rd_cnt != nb);
    assign wr_evt      = M_AXI_BREADY && M_AXI_BVALID && (wr_cnt != nb);
    assign rd_next     = rd_cnt + {8'd0, rd_evt};
    assign wr_next     = wr_cnt + {8'd0, wr_evt};
    assign all_done    = (rd_next == nb) && (wr_next == nb);
    // Timer register reaches TIMEOUT_CYCLES-1 on this edge, so abort now.
    assign timeout_hit = !rd_evt && !wr_evt && (timer == TW'(TIMEOUT_CYCLES - 2));

    assign unused_bresp0 = M_AXI_BRESP[0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            job_ready    <= 1'b1;
            rd_start     <= 1'b0;
            wr_start     <= 1'b0;
            rd_src_addr  <= '0;
            wr_dst_addr  <= '0;
            rd_size      <= '0;
            wr_size      <= '0;
            M_AXI_BREADY <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            nb           <= '0;
            rd_cnt       <= '0;
            wr_cnt       <= '0;
            timer        <= '0;
        end else begin
            rd_start <= 1'b0;
            wr_start <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (job_valid && job_ready) begin
                        rd_src_addr <= job_src;
                        wr_dst_addr <= job_dst;
                        rd_size     <= job_size;
                        wr_size     <= job_size;
                        nb          <= {1'b0, job_size[15:8]} + 9'd1;
                        rd_cnt      <= '0;
                        wr_cnt      <= '0;
                        timer       <= '0;
                        err         <= 1'b0;
                        job_ready   <= 1'b0;
                        busy        <= 1'b1;
                        rd_start    <= 1'b1;
                        wr_start    <= 1'b1;
                        state       <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    M_AXI_BREADY <= 1'b1;
                    state        <= RUN;
                end
                RUN: begin
                    rd_cnt <= rd_next;
                    wr_cnt <= wr_next;
                    if (wr_evt && M_AXI_BRESP[1]) begin
                        err <= 1'b1;
                    end
                    if (rd_evt || wr_evt) begin
                        timer <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                    if (all_done || timeout_hit) begin
                        if (!all_done) begin
                            err <= 1'b1;
                        end
                        done         <= 1'b1;
                        busy         <= 1'b0;
                        M_AXI_BREADY <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    job_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    a_start_pair: assert property (@(posedge clk) disable iff (!rst_n) rd_start == wr_start);
    a_cnt_sat:    assert property (@(posedge clk) disable iff (!rst_n) (rd_cnt <= nb) && (wr_cnt <= nb));
    a_done_idle:  assert property (@(posedge clk) disable iff (!rst_n) done |-> !busy && !job_ready);

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Randomized bench for dma_xfer_ctrl: counts RLAST/B events per job and predicts done/err timing.
module tb_dma_xfer_ctrl;

    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_valid;
    logic          job_ready;
    logic [DW-1:0] job_src;
    logic [DW-1:0] job_dst;
    logic [15:0]   job_size;
    logic          rd_start;
    logic [DW-1:0] rd_src_addr;
    logic [15:0]   rd_size;
    logic          wr_start;
    logic [DW-1:0] wr_dst_addr;
    logic [15:0]   wr_size;
    logic          M_AXI_RVALID;
    logic          M_AXI_RREADY;
    logic          M_AXI_RLAST;
    logic          M_AXI_BVALID;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BREADY;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    dma_xfer_ctrl #(
        .C_AXI_DATA_WIDTH (DW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_src      (job_src),
        .job_dst      (job_dst),
        .job_size     (job_size),
        .rd_start     (rd_start),
        .rd_src_addr  (rd_src_addr),
        .rd_size      (rd_size),
        .wr_start     (wr_start),
        .wr_dst_addr  (wr_dst_addr),
        .wr_size      (wr_size),
        .M_AXI_RVALID (M_AXI_RVALID),
        .M_AXI_RREADY (M_AXI_RREADY),
        .M_AXI_RLAST  (M_AXI_RLAST),
        .M_AXI_BVALID (M_AXI_BVALID),
        .M_AXI_BRESP  (M_AXI_BRESP),
        .M_AXI_BREADY (M_AXI_BREADY),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        M_AXI_RVALID = 1'b0;
        M_AXI_RREADY = 1'b0;
        M_AXI_RLAST  = 1'b0;
        M_AXI_BVALID = 1'b0;
        M_AXI_BRESP  = 2'b00;
    endtask

    task automatic start_job(input logic [DW-1:0] src, input logic [DW-1:0] dst, input logic [15:0] size);
        check("ready_before_accept", job_ready, 1);
        job_valid = 1'b1;
        job_src   = src;
        job_dst   = dst;
        job_size  = size;
        tick();
        job_valid = 1'b0;
        check("rd_start_pulse", rd_start, 1);
        check("wr_start_pulse", wr_start, 1);
        check("rd_src_addr", rd_src_addr, src);
        check("wr_dst_addr", wr_dst_addr, dst);
        check("rd_size", rd_size, size);
        check("wr_size", wr_size, size);
        check("busy_launch", busy, 1);
        check("ready_launch", job_ready, 0);
        check("err_cleared", err, 0);
        check("bready_launch", M_AXI_BREADY, 0);
    endtask

    // mode 0: random events and responses; 1: fixed B-first schedule; 2: reads only, no B.
    task automatic drive_run(input logic [15:0] size, input int mode, input int err_b,
                             input logic [DW-1:0] src, input logic [DW-1:0] dst,
                             output logic exp_err);
        int  nb;
        int  rd;
        int  wr;
        int  last;
        bit  fin;
        bit  r_ev;
        bit  b_ev;
        bit  exp_done;
        logic [1:0] br;
        nb      = int'(size[15:8]) + 1;
        rd      = 0;
        wr      = 0;
        last    = 0;
        fin     = 0;
        exp_err = 1'b0;
        idle_bus();
        tick();
        check("run_bready", M_AXI_BREADY, 1);
        check("run_no_start", rd_start, 0);
        check("run_busy", busy, 1);
        for (int k = 1; k <= 3000 && !fin; k++) begin
            r_ev = 0;
            b_ev = 0;
            case (mode)
                0: begin
                    r_ev = (rd < nb) && (($urandom % 3 == 0) || (k - last >= 10));
                    b_ev = (wr < nb) && (($urandom % 3 == 0) || (k - last >= 10));
                end
                1: begin
                    b_ev = (wr < nb) && (k == 2 || k == 4 || k == 6);
                    r_ev = (rd < nb) && (k == 6 || k == 8 || k == 10);
                end
                default: begin
                    r_ev = (rd < nb) && (k % 4 == 0);
                end
            endcase
            if (r_ev) begin
                M_AXI_RVALID = 1'b1;
                M_AXI_RREADY = 1'b1;
                M_AXI_RLAST  = 1'b1;
            end else begin
                M_AXI_RVALID = 1'($urandom);
                M_AXI_RREADY = 1'($urandom);
                M_AXI_RLAST  = 1'($urandom);
                if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RLAST = 1'b0;
            end
            if (err_b == wr + 1) br = 2'b10;
            else if (mode == 0 && ($urandom % 8 == 0)) br = {1'b1, 1'($urandom)};
            else br = {1'b0, 1'($urandom)};
            M_AXI_BVALID = b_ev;
            M_AXI_BRESP  = b_ev ? br : 2'($urandom);
            tick();
            if (r_ev) rd++;
            if (b_ev) begin
                wr++;
                if (br[1]) exp_err = 1'b1;
            end
            if (r_ev || b_ev) last = k;
            exp_done = (rd == nb) && (wr == nb);
            if (!exp_done && (k + 1) - last == TO) begin
                exp_done = 1;
                exp_err  = 1'b1;
            end
            check("done", done, exp_done);
            if (exp_done) begin
                check("err_at_done", err, exp_err);
                check("busy_at_done", busy, 0);
                check("bready_at_done", M_AXI_BREADY, 0);
                check("rd_src_stable", rd_src_addr, src);
                check("wr_dst_stable", wr_dst_addr, dst);
                fin = 1;
            end else begin
                check("busy_run", busy, 1);
                check("ready_run", job_ready, 0);
            end
        end
        idle_bus();
    endtask

    task automatic finish_job(input logic exp_err);
        tick();
        check("ready_after_done", job_ready, 1);
        check("done_single", done, 0);
        check("busy_idle", busy, 0);
        check("no_start_idle", rd_start, 0);
        check("err_held", err, exp_err);
    endtask

    task automatic full_job(input logic [DW-1:0] src, input logic [DW-1:0] dst,
                            input logic [15:0] size, input int mode, input int err_b);
        logic e;
        start_job(src, dst, size);
        drive_run(size, mode, err_b, src, dst, e);
        finish_job(e);
    endtask

    initial begin
        logic e;
        rst_n     = 1'b0;
        job_valid = 1'b0;
        job_src   = '0;
        job_dst   = '0;
        job_size  = '0;
        idle_bus();
        repeat (3) tick();
        check("rst_ready", job_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bready", M_AXI_BREADY, 0);
        check("rst_rd_start", rd_start, 0);
        check("rst_src", rd_src_addr, 0);
        check("rst_size", wr_size, 0);
        rst_n = 1'b1;
        tick();

        full_job(32'h1000, 32'h8000, 16'h00FF, 1, 0);
        full_job(32'h2000, 32'h3000, 16'h02FF, 1, 0);

        start_job(32'h4000, 32'h5000, 16'h01FF);
        drive_run(16'h01FF, 1, 2, 32'h4000, 32'h5000, e);
        finish_job(e);
        check("err_sticky_idle", err, 1);
        full_job(32'h4100, 32'h5100, 16'h0010, 0, 0);

        full_job(32'h6000, 32'h7000, 16'h00FF, 2, 0);

        start_job(32'hA000, 32'hB000, 16'h01FF);
        tick();
        M_AXI_RVALID = 1'b1;
        M_AXI_RREADY = 1'b1;
        M_AXI_RLAST  = 1'b1;
        tick();
        idle_bus();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_done", done, 0);
        check("midrun_rst_ready", job_ready, 1);
        check("midrun_rst_bready", M_AXI_BREADY, 0);
        check("midrun_rst_src", rd_src_addr, 0);
        tick();
        check("midrun_rst_no_done", done, 0);
        full_job(32'hA100, 32'hB100, 16'h01FF, 0, 0);

        start_job(32'hC000, 32'hD000, 16'h0103);
        job_valid = 1'b1;
        job_src   = 32'hC800;
        job_dst   = 32'hD800;
        job_size  = 16'h0207;
        drive_run(16'h0103, 0, 0, 32'hC000, 32'hD000, e);
        finish_job(e);
        full_job(32'hC800, 32'hD800, 16'h0207, 0, 0);

        for (int j = 0; j < 20; j++) begin
            logic [DW-1:0] s;
            logic [DW-1:0] d;
            logic [15:0]   z;
            s = $urandom;
            d = $urandom;
            z = {8'($urandom_range(0, 3)), 8'($urandom)};
            full_job(s, d, z, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
